reg_mux21: RTL and testbench



---
 rtl/reg_mux21.sv | 60 ++++++
 tb/tb_reg_mux21.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_mux21.sv
// reg_mux21: registered 2-to-1 data selector with an internal select
// synchroniser. Y holds the chosen source, sel_out reports which source
// produced it, and sel_chg pulses for one cycle when that source changes.
module reg_mux21 #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic             sel_out,
    output logic             sel_chg
);

    // Select value seen by the data path after synchronisation.
    logic s_eff;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            // Caller guarantees S is already in the clk domain; use it as-is.
            assign s_eff = S;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;

            // Shift the raw select through the synchroniser every cycle, independent of en.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync <= '0;
                end else begin
                    sync[0] <= S;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end

            assign s_eff = sync[SYNC_STAGES-1];
        end
    endgenerate

    // Load the selected source and flag a change of source when enabled; hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            Y       <= '0;
            sel_out <= 1'b0;
            sel_chg <= 1'b0;
        end else if (en) begin
            Y       <= s_eff ? D1 : D0;
            sel_out <= s_eff;
            sel_chg <= (s_eff != sel_out);
        end else begin
            sel_chg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_mux21.sv
// tb_reg_mux21: directed test-plan sequences followed by random stimulus,
// checked every cycle against a history-based reference model.
module tb_reg_mux21;

    localparam int WA = 16;
    localparam int NA = 2;
    localparam int WB = 8;

    logic          clk;
    logic          reset;
    logic          en;
    logic          S;
    logic [WA-1:0] d0_a, d1_a, y_a;
    logic          sel_a, chg_a;
    logic [WB-1:0] d0_b, d1_b, y_b;
    logic          sel_b, chg_b;

    int n_checks = 0;
    int n_fail   = 0;

    reg_mux21 #(.WIDTH(WA), .SYNC_STAGES(NA)) dut_a (
        .clk(clk), .reset(reset), .D0(d0_a), .D1(d1_a), .S(S), .en(en),
        .Y(y_a), .sel_out(sel_a), .sel_chg(chg_a)
    );

    reg_mux21 #(.WIDTH(WB), .SYNC_STAGES(0)) dut_b (
        .clk(clk), .reset(reset), .D0(d0_b), .D1(d1_b), .S(S), .en(en),
        .Y(y_b), .sel_out(sel_b), .sel_chg(chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the select in force at an edge is the raw S sampled
    // NA edges earlier (zero right after reset); the output registers then
    // follow the load/hold rules directly.
    logic          s_hist[$];
    logic [WA-1:0] m_y_a;
    logic          m_sel_a, m_chg_a;
    logic [WB-1:0] m_y_b;
    logic          m_sel_b, m_chg_b;

    always @(posedge clk) begin
        logic sa;
        if (reset) begin
            s_hist.delete();
            for (int i = 0; i < NA; i++) s_hist.push_back(1'b0);
            m_y_a = '0; m_sel_a = 1'b0; m_chg_a = 1'b0;
            m_y_b = '0; m_sel_b = 1'b0; m_chg_b = 1'b0;
        end else begin
            sa = s_hist[0];
            if (en) begin
                m_chg_a = (sa != m_sel_a);
                m_y_a   = sa ? d1_a : d0_a;
                m_sel_a = sa;
                m_chg_b = (S != m_sel_b);
                m_y_b   = S ? d1_b : d0_b;
                m_sel_b = S;
            end else begin
                m_chg_a = 1'b0;
                m_chg_b = 1'b0;
            end
            s_hist.push_back(S);
            void'(s_hist.pop_front());
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        check("model_y_a",   32'(y_a),   32'(m_y_a));
        check("model_sel_a", 32'(sel_a), 32'(m_sel_a));
        check("model_chg_a", 32'(chg_a), 32'(m_chg_a));
        check("model_y_b",   32'(y_b),   32'(m_y_b));
        check("model_sel_b", 32'(sel_b), 32'(m_sel_b));
        check("model_chg_b", 32'(chg_b), 32'(m_chg_b));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; S = 1'b1;
        d0_a = 16'hAAAA; d1_a = 16'h5555;
        d0_b = 8'h11;    d1_b = 8'h22;

        // Reset
        cyc(2);
        check("rst_y",   32'(y_a),   32'h0);
        check("rst_sel", 32'(sel_a), 32'h0);
        check("rst_chg", 32'(chg_a), 32'h0);

        // Select-0 data tracking; unselected input ignored
        reset = 1'b0; S = 1'b0; d0_a = 16'h1234;
        cyc(1);
        check("sel0_track", 32'(y_a), 32'h1234);
        d1_a = 16'hFFFF;
        cyc(1);
        check("sel0_unsel", 32'(y_a), 32'h1234);

        // Select switch latency
        d0_a = 16'h00AB; d1_a = 16'h7FCD;
        cyc(3);
        S = 1'b1;
        cyc(1);
        check("lat_e1_y",   32'(y_a),   32'h00AB);
        check("lat_e1_b",   32'(y_b),   32'h22);
        cyc(1);
        check("lat_e2_y",   32'(y_a),   32'h00AB);
        check("lat_e2_sel", 32'(sel_a), 32'h0);
        cyc(1);
        check("lat_e3_y",   32'(y_a),   32'h7FCD);
        check("lat_e3_sel", 32'(sel_a), 32'h1);
        check("lat_e3_chg", 32'(chg_a), 32'h1);
        cyc(1);
        check("lat_e4_chg", 32'(chg_a), 32'h0);

        // Enable hold, then re-enable with a different source
        en = 1'b0; S = 1'b0; d0_a = 16'h0101; d1_a = 16'h0202;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("hold_y",   32'(y_a),   32'h7FCD);
            check("hold_sel", 32'(sel_a), 32'h1);
            check("hold_chg", 32'(chg_a), 32'h0);
            S = ~S;
        end
        S = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(1);
        check("reen_y",   32'(y_a),   32'h0101);
        check("reen_chg", 32'(chg_a), 32'h1);

        // Mid-operation reset with a pending select change
        S = 1'b1;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_y",   32'(y_a),   32'h0);
        check("mid_rst_sel", 32'(sel_a), 32'h0);
        check("mid_rst_y_b", 32'(y_b),   32'h0);
        reset = 1'b0;
        cyc(3);
        check("post_rst_y",   32'(y_a),   32'h0202);
        check("post_rst_chg", 32'(chg_a), 32'h1);

        // Unsynchronised instance follows S on the next edge
        for (int i = 0; i < 4; i++) begin
            S = ~S;
            cyc(1);
            check("nosync_y", 32'(y_b), S ? 32'h22 : 32'h11);
        end

        // Random stimulus, checked by the model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3, 0) == 0) S = ~S;
            en    = ($urandom_range(4, 0) != 0);
            reset = ($urandom_range(39, 0) == 0);
            d0_a  = 16'($urandom);
            d1_a  = 16'($urandom);
            d0_b  = 8'($urandom);
            d1_b  = 8'($urandom);
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
